fpmult_op_sequencer: RTL and testbench
======================================

// Module: fpmult_op_sequencer
// PURPOSE
// - Moore FSM that sequences one FP multiply through the fpmult datapath: operand load, zero check, exponent add/check,
//   multi-cycle mantissa multiply, normalise, round, final load, then holds result-ready until acknowledged.
// - Consumes the registered zero flag from the zero-detect unit and the exponent/round status flags; drives every load/enable.
// PARAMETERS
// - MUL_CYCLES  4  cycles mul_en_o stays high per operation (>=1)
// - CNT_W       3  multiply-counter width; 2**CNT_W >= MUL_CYCLES required
// PORTS
// - clk           in   1  clock, rising edge
// - rst           in   1  asynchronous, active-low reset
// - beg_fsm       in   1  start request, sampled only in IDLE
// - ack_fsm       in   1  host acknowledge, sampled only in READY
// - zero_flag_i   in   1  registered zero-operand flag (valid in ZERO_CHK)
// - exp_ovf_i     in   1  exponent overflow (valid in EXP_CHK)
// - exp_unf_i     in   1  exponent underflow (valid in EXP_CHK)
// - norm_needed_i in   1  mantissa product MSB set (valid in NORM)
// - round_ovf_i   in   1  rounding carried out of mantissa (valid in ROUND)
// - load_ops_o    out  1  load operand regs + zero-detect reg
// - load_exp_o    out  1  load exponent adder result
// - mul_en_o      out  1  mantissa multiplier enable
// - load_norm_o   out  1  load normaliser; norm_shift_o = shift right by 1
// - norm_shift_o  out  1  copy of norm_needed_i during NORM, else 0
// - load_round_o  out  1  load rounding register
// - load_final_o  out  1  load output result register
// - zero_res_o    out  1  latched: result is signed zero
// - exc_o         out  2  latched: 00 none, 01 overflow, 10 underflow
// - ready_o       out  1  result valid, held until ack_fsm
// - state_o       out  4  current state code
// BEHAVIOUR
// - Reset (async, any state): state IDLE, counter 0, all outputs 0, latched flags cleared. Exit on first edge after rst=1.
// - Codes: IDLE0 LOAD_OPS1 ZERO_CHK2 EXP_ADD3 EXP_CHK4 MANT_MUL5 NORM6 ROUND7 FINAL8 EXC9 READY10; codes 11-15 -> IDLE next edge.
// - Outputs decoded from state register only (Moore); each load_* high for exactly the cycles of its state.
// - IDLE: beg_fsm=1 -> LOAD_OPS. LOAD_OPS: clear zero_res_o, exc_o, renorm flag -> ZERO_CHK.
// - ZERO_CHK: zero_res_o <= zero_flag_i; zero with bypass -> FINAL, else EXP_ADD. EXP_ADD -> EXP_CHK.
// - EXP_CHK: if !zero_res_o and (ovf|unf): exc_o <= ovf ? 01 : 10 (ovf wins), -> EXC; else MANT_MUL, counter 0.
// - MANT_MUL: mul_en_o=1; counter increments; leaves to NORM when counter==MUL_CYCLES-1 (exactly MUL_CYCLES cycles).
// - NORM -> ROUND. ROUND: round_ovf_i=1 and renorm flag clear -> set flag, NORM; otherwise FINAL (max one re-normalise).
// - EXC -> FINAL. FINAL -> READY. READY: ready_o=1; ack_fsm=1 -> IDLE; zero_res_o/exc_o held through READY.
// - Latency (edge 0 samples beg_fsm): ready_o high after edge 7+MUL_CYCLES; +2 with re-normalise; exception after edge 6.
// - beg_fsm in READY ignored even with ack_fsm; held-high beg yields back-to-back ops with exactly one IDLE cycle between.
// - ack_fsm outside READY has no effect.
// CONFIGURATION
// - FPMULT_ZERO_BYPASS_EN defined: zero operand goes ZERO_CHK -> FINAL; ready_o after edge 3; mul_en_o never asserted.
// - Not defined: zero still latched into zero_res_o, exceptions still suppressed, but full path runs; constant latency 7+MUL_CYCLES.
// TESTING
// - Reset mid MANT_MUL: rst=0 -> state_o=0, all outputs 0 same cycle; rst=1, beg_fsm=0 -> stays IDLE.
// - Normal, MUL_CYCLES=4, flags 0, norm_needed_i=1: mul_en_o high edges 4..7, norm_shift_o=1 in NORM, ready_o after edge 11,
//   held 5 cycles with ack_fsm=0, IDLE one edge after ack_fsm=1.
// - zero_flag_i=1, bypass defined: ready_o after edge 3, zero_res_o=1, exc_o=00; undefined: ready_o after edge 11, zero_res_o=1.
// - exp_ovf_i=1 and exp_unf_i=1 in EXP_CHK: exc_o=01, state 9 then 8, ready_o after edge 6, mul_en_o never high.
// - round_ovf_i stuck 1: exactly one ROUND->NORM loop, ready_o after edge 13 (MUL_CYCLES=4).
// - beg_fsm held 1, ack_fsm pulsed in READY: second LOAD_OPS two edges after ack; ack_fsm=1 in IDLE ignored.

Source files
------------

// File: rtl/fpmult_op_sequencer.sv
//==============================================================================
// fpmult_op_sequencer: Moore FSM that sequences one FP multiply through the fpmult datapath.
// Optional feature macro FPMULT_ZERO_BYPASS_EN: zero operands skip from ZERO_CHK straight to FINAL.
// Revision: 1.0
//==============================================================================
`default_nettype none

module fpmult_op_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       beg_fsm,
    input  logic       ack_fsm,
    input  logic       zero_flag_i,
    input  logic       exp_ovf_i,
    input  logic       exp_unf_i,
    input  logic       norm_needed_i,
    input  logic       round_ovf_i,
    output logic       load_ops_o,
    output logic       load_exp_o,
    output logic       mul_en_o,
    output logic       load_norm_o,
    output logic       norm_shift_o,
    output logic       load_round_o,
    output logic       load_final_o,
    output logic       zero_res_o,
    output logic [1:0] exc_o,
    output logic       ready_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD_OPS = 4'd1,
        ST_ZERO_CHK = 4'd2,
        ST_EXP_ADD  = 4'd3,
        ST_EXP_CHK  = 4'd4,
        ST_MANT_MUL = 4'd5,
        ST_NORM     = 4'd6,
        ST_ROUND    = 4'd7,
        ST_FINAL    = 4'd8,
        ST_EXC      = 4'd9,
        ST_READY    = 4'd10
    } state_t;

    localparam logic [1:0]       EXC_NONE = 2'b00;
    localparam logic [1:0]       EXC_OVF  = 2'b01;
    localparam logic [1:0]       EXC_UNF  = 2'b10;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] mul_cnt;
    logic             renorm_done;
    logic             zero_res;
    logic [1:0]       exc;
    logic             exp_exc;

    // A zero result masks any exponent exception reported for the same operation.
    assign exp_exc = !zero_res && (exp_ovf_i || exp_unf_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_ops_o   = 1'b0;
        load_exp_o   = 1'b0;
        mul_en_o     = 1'b0;
        load_norm_o  = 1'b0;
        norm_shift_o = 1'b0;
        load_round_o = 1'b0;
        load_final_o = 1'b0;
        ready_o      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (beg_fsm) state_nxt = ST_LOAD_OPS;
            end
            ST_LOAD_OPS: begin
                load_ops_o = 1'b1;
                state_nxt  = ST_ZERO_CHK;
            end
            ST_ZERO_CHK: begin
`ifdef FPMULT_ZERO_BYPASS_EN
                state_nxt = zero_flag_i ? ST_FINAL : ST_EXP_ADD;
`else
                state_nxt = ST_EXP_ADD;
`endif
            end
            ST_EXP_ADD: begin
                load_exp_o = 1'b1;
                state_nxt  = ST_EXP_CHK;
            end
            ST_EXP_CHK: begin
                state_nxt = exp_exc ? ST_EXC : ST_MANT_MUL;
            end
            ST_MANT_MUL: begin
                mul_en_o = 1'b1;
                if (mul_cnt == MUL_LAST) state_nxt = ST_NORM;
            end
            ST_NORM: begin
                load_norm_o  = 1'b1;
                norm_shift_o = norm_needed_i;
                state_nxt    = ST_ROUND;
            end
            ST_ROUND: begin
                load_round_o = 1'b1;
                state_nxt    = (round_ovf_i && !renorm_done) ? ST_NORM : ST_FINAL;
            end
            ST_FINAL: begin
                load_final_o = 1'b1;
                state_nxt    = ST_READY;
            end
            ST_EXC: begin
                state_nxt = ST_FINAL;
            end
            ST_READY: begin
                ready_o = 1'b1;
                if (ack_fsm) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt     <= '0;
            renorm_done <= 1'b0;
            zero_res    <= 1'b0;
            exc         <= EXC_NONE;
        end else begin
            case (state)
                ST_LOAD_OPS: begin
                    zero_res    <= 1'b0;
                    exc         <= EXC_NONE;
                    renorm_done <= 1'b0;
                end
                ST_ZERO_CHK: begin
                    zero_res <= zero_flag_i;
                end
                ST_EXP_CHK: begin
                    mul_cnt <= '0;
                    if (exp_exc) exc <= exp_ovf_i ? EXC_OVF : EXC_UNF;
                end
                ST_MANT_MUL: begin
                    mul_cnt <= mul_cnt + CNT_ONE;
                end
                ST_ROUND: begin
                    if (round_ovf_i) renorm_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign zero_res_o = zero_res;
    assign exc_o      = exc;
    assign state_o    = state;

endmodule

`default_nettype wire

// File: tb/tb_fpmult_op_sequencer.sv
//==============================================================================
// tb_fpmult_op_sequencer: directed table-driven bench for fpmult_op_sequencer (MUL_CYCLES=4).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_fpmult_op_sequencer;

    localparam int MUL_CYCLES = 4;
    localparam int CNT_W      = 3;
`ifdef FPMULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       beg_fsm = 1'b0;
    logic       ack_fsm = 1'b0;
    logic       zero_flag_i = 1'b0;
    logic       exp_ovf_i = 1'b0;
    logic       exp_unf_i = 1'b0;
    logic       norm_needed_i = 1'b0;
    logic       round_ovf_i = 1'b0;
    logic       load_ops_o;
    logic       load_exp_o;
    logic       mul_en_o;
    logic       load_norm_o;
    logic       norm_shift_o;
    logic       load_round_o;
    logic       load_final_o;
    logic       zero_res_o;
    logic [1:0] exc_o;
    logic       ready_o;
    logic [3:0] state_o;
    logic [10:0] all_outs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpmult_op_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .beg_fsm       (beg_fsm),
        .ack_fsm       (ack_fsm),
        .zero_flag_i   (zero_flag_i),
        .exp_ovf_i     (exp_ovf_i),
        .exp_unf_i     (exp_unf_i),
        .norm_needed_i (norm_needed_i),
        .round_ovf_i   (round_ovf_i),
        .load_ops_o    (load_ops_o),
        .load_exp_o    (load_exp_o),
        .mul_en_o      (mul_en_o),
        .load_norm_o   (load_norm_o),
        .norm_shift_o  (norm_shift_o),
        .load_round_o  (load_round_o),
        .load_final_o  (load_final_o),
        .zero_res_o    (zero_res_o),
        .exc_o         (exc_o),
        .ready_o       (ready_o),
        .state_o       (state_o)
    );

    assign all_outs = {load_ops_o, load_exp_o, mul_en_o, load_norm_o, norm_shift_o,
                       load_round_o, load_final_o, zero_res_o, exc_o, ready_o};

    typedef struct {
        logic zf, ovf, unf, nn, rovf;
        int   lat, zr, exc, muls, nsh;
    } vec_t;

    vec_t vt[8];
    int   st_log[16];
    int   mul_log[16];
    int   nsh_log[16];
    int   rdy_log[16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input vec_t v);
        zero_flag_i   = v.zf;
        exp_ovf_i     = v.ovf;
        exp_unf_i     = v.unf;
        norm_needed_i = v.nn;
        round_ovf_i   = v.rovf;
    endtask

    // Starts an op (edge 0 samples beg) and logs the state after edges 0..n-1.
    task automatic capture(input int n);
        beg_fsm = 1'b1;
        for (int e = 0; e < n; e++) begin
            step();
            beg_fsm = 1'b0;
            st_log[e]  = int'(state_o);
            mul_log[e] = int'(mul_en_o);
            nsh_log[e] = int'(norm_shift_o);
            rdy_log[e] = int'(ready_o);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready_o && n < 40) begin
            step();
            n++;
        end
        check(name, int'(ready_o), 1);
    endtask

    task automatic run_op(output int lat, output int muls, output int nsh);
        beg_fsm = 1'b1;
        step();
        beg_fsm = 1'b0;
        lat = 0; muls = 0; nsh = 0;
        while (!ready_o && lat < 40) begin
            muls += int'(mul_en_o);
            nsh  += int'(norm_shift_o);
            step();
            lat++;
        end
    endtask

    task automatic ack_op();
        ack_fsm = 1'b1;
        step();
        ack_fsm = 1'b0;
    endtask

    initial begin
        int lat, muls, nsh;
        //        zf    ovf   unf   nn    rovf  lat                  zr exc muls            nsh
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11,                  0, 0,  4,              1};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11,                  0, 0,  4,              0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6,                   0, 1,  0,              0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6,                   0, 2,  0,              0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6,                   0, 1,  0,              0};
        vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 13,                  0, 0,  4,              2};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BYP ? 3 : 11,        1, 0,  BYP ? 0 : 4,    0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BYP ? 3 : 13,        1, 0,  BYP ? 0 : 4,    0};

        // Reset is asserted from time 0.
        #1;
        check("reset_state", int'(state_o), 0);
        check("reset_outs", int'(all_outs), 0);
        step(); step();
        rst = 1'b1;
        step();
        check("idle_after_reset", int'(state_o), 0);

        for (int i = 0; i < 8; i++) begin
            set_flags(vt[i]);
            run_op(lat, muls, nsh);
            check($sformatf("v%0d_latency", i), lat, vt[i].lat);
            check($sformatf("v%0d_mul_cycles", i), muls, vt[i].muls);
            check($sformatf("v%0d_norm_shift", i), nsh, vt[i].nsh);
            check($sformatf("v%0d_zero_res", i), int'(zero_res_o), vt[i].zr);
            check($sformatf("v%0d_exc", i), int'(exc_o), vt[i].exc);
            for (int k = 0; k < 5; k++) begin
                step();
                check($sformatf("v%0d_ready_hold%0d", i, k), int'(ready_o), 1);
            end
            check($sformatf("v%0d_exc_held", i), int'(exc_o), vt[i].exc);
            ack_op();
            check($sformatf("v%0d_idle_after_ack", i), int'(state_o), 0);
            check($sformatf("v%0d_ready_drop", i), int'(ready_o), 0);
        end

        // Normal op timeline: multiplier enabled after edges 4..7, NORM after edge 8.
        set_flags(vt[0]);
        capture(12);
        check("norm_mul_e3", mul_log[3], 0);
        check("norm_mul_e4", mul_log[4], 1);
        check("norm_mul_e7", mul_log[7], 1);
        check("norm_mul_e8", mul_log[8], 0);
        check("norm_state_e8", st_log[8], 6);
        check("norm_shift_e8", nsh_log[8], 1);
        check("norm_ready_e10", rdy_log[10], 0);
        check("norm_ready_e11", rdy_log[11], 1);
        ack_op();

        // Exception timeline: EXC then FINAL then READY after edge 6.
        set_flags(vt[2]);
        capture(7);
        check("exc_state_e4", st_log[4], 9);
        check("exc_state_e5", st_log[5], 8);
        check("exc_ready_e5", rdy_log[5], 0);
        check("exc_ready_e6", rdy_log[6], 1);
        ack_op();

        // Asynchronous reset while multiplying.
        set_flags(vt[1]);
        capture(6);
        check("mid_state_mul", st_log[5], 5);
        rst = 1'b0;
        #1;
        check("mid_reset_state", int'(state_o), 0);
        check("mid_reset_outs", int'(all_outs), 0);
        step();
        rst = 1'b1;
        step(); step();
        check("mid_reset_stay_idle", int'(state_o), 0);

        // Back-to-back ops with beg held high; beg ignored in READY even with ack.
        set_flags(vt[1]);
        beg_fsm = 1'b1;
        step();
        wait_ready("b2b_first_ready");
        ack_fsm = 1'b1;
        step();
        check("b2b_idle_after_ack", int'(state_o), 0);
        step();
        check("b2b_second_load_ops", int'(state_o), 1);
        step();
        check("b2b_ack_ignored_busy", int'(state_o), 2);
        beg_fsm = 1'b0;
        ack_fsm = 1'b0;
        wait_ready("b2b_second_ready");
        ack_fsm = 1'b1;
        step();
        check("b2b_idle_again", int'(state_o), 0);
        step();
        check("ack_in_idle_ignored", int'(state_o), 0);
        ack_fsm = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
